fcw_seq_table: RTL
==================

# fcw_seq_table

Parametrised frequency-control-word (FCW) table with a built-in note sequencer for the tone-generation path. It holds DEPTH programmable FCWs, each WIDTH bits, and has a host read/write port. An autonomous playback engine steps through entries 0..seq_last, holding each entry for a programmable number of cycles. It sits between the host/button control logic and the NCO phase accumulator, and drives the accumulator's FCW input directly.

## Interface
- WIDTH, 24: FCW bit width.
- DEPTH, 8: number of table entries; must be a power of two, at least 4.
- ADDR_W, $clog2(DEPTH): address width (derived).
- TEMPO_W, 24: width of the note-duration count.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  host write strobe.
- rd_en  in  1  host read strobe.
- addr  in  ADDR_W  host entry index.
- d_in  in  WIDTH  host write data.
- d_out  out  WIDTH  host read data (registered).
- play  in  1  level: 1 = run the sequencer, 0 = pause.
- restart  in  1  pulse: return the sequencer to IDLE at index 0.
- seq_last  in  ADDR_W  last index of the playback loop.
- tempo  in  TEMPO_W  cycles per note; a value of 0 is treated as 1.
- fcw_out  out  WIDTH  FCW to the NCO.
- fcw_valid  out  1  one-cycle pulse whenever fcw_out takes a new table value.
- seq_idx  out  ADDR_W  index currently playing.

## Operation
- **Storage:** register array of DEPTH × WIDTH.
- **Host write:** when wr_en is high, table[addr] <= d_in.
- **Host read:** when rd_en is high, d_out <= table[addr] on the next edge. When rd_en is low, d_out holds.
- **Read/write collision:** a read and a write to the same address in the same cycle return the old data.
- **Sequencer read path:** the sequencer has its own read path, independent of the host port. There is no arbitration.
- **Sequencer FSM states:**
  - IDLE: fcw_out = 0, seq_idx = 0, cnt = 0. If play is high, load fcw_out <= table[0], pulse fcw_valid, and go to PLAY.
  - PLAY: cnt increments each cycle. When cnt == max(tempo,1)-1:
    - nidx = (seq_idx >= seq_last) ? 0 : seq_idx+1.
    - seq_idx <= nidx, fcw_out <= table[nidx], pulse fcw_valid, cnt <= 0.
    - If play is low, go to PAUSE instead.
  - PAUSE: fcw_out = 0 (mute). seq_idx holds and cnt is cleared. If play is high, fcw_out <= table[seq_idx], pulse fcw_valid, and go to PLAY.
- **restart:** has priority over everything else in the FSM. It forces IDLE, seq_idx = 0, cnt = 0 and fcw_out = 0 on the next edge. If play is also high, playback restarts from IDLE in the following cycle.
- **seq_last changed mid-play:** if seq_idx > seq_last, the next step wraps to 0.
- **seq_last = 0:** entry 0 repeats. fcw_valid still pulses every tempo cycles.
- **tempo changed mid-note:** takes effect on the next comparison. If cnt already exceeds the new tempo-1, cnt keeps incrementing and wraps modulo 2^TEMPO_W.
- **Writing the entry currently playing:** fcw_out does not change until the next step or resume.

## Timing
- **Reset values** (all asynchronous on rst_n low): fcw_out = 0, fcw_valid = 0, seq_idx = 0, d_out = 0, state = IDLE, cnt = 0, table contents per Configuration.
- **Host read latency:** 1 cycle. Write latency: 1 cycle.
- **Play start:** play goes high in IDLE at edge N; fcw_out = table[0] and fcw_valid = 1 after edge N.
- **Note duration:** each note lasts exactly max(tempo,1) cycles. fcw_valid pulses are spaced exactly tempo cycles apart.
- **Pause:** fcw_out goes to 0 one cycle after play falls.
- **Reset mid-note:** the sequencer aborts immediately. No fcw_valid pulse is issued.

## Configuration
- FCW_SEQ_DEFAULTS_EN defined: reset loads the default table.
  - entry 0 = 24'h00EC3C (440 Hz), entry 1 = 24'h010905 (494 Hz), entry 2 = 24'h01194B (523 Hz), entry 3 = 24'h013BCD (587 Hz).
  - Remaining entries = 0.
  - Defaults are truncated or zero-extended to WIDTH.
- FCW_SEQ_DEFAULTS_EN undefined: reset clears all entries to 0.

## Structure
- **Shared package fcw_pkg:**
  - state enum (IDLE, PLAY, PAUSE);
  - default FCW constants FCW_A4, FCW_B4, FCW_C5, FCW_D5;
  - DEFAULT_WIDTH = 24.
- **Sub-module fcw_seq_ctrl:** FSM, duration counter and index generator. It drives a read address into the table and receives the table word back.
- **Top level:** the table array and the host port stay in the top level.

## Test plan
- **Defaults:** FCW_SEQ_DEFAULTS_EN defined. Release reset, then rd_en with addr 2 → d_out = 24'h01194B one cycle later; all outputs were 0 during reset.
- **Read/write collision:** wr_en and rd_en to addr 1 in the same cycle, d_in = 24'h123456 → d_out = 24'h010905. A second read returns 24'h123456.
- **Sequence loop:** tempo = 4, seq_last = 2, play = 1 → fcw_out steps through 00EC3C, 010905, 01194B, 00EC3C, holding each for 4 cycles, with fcw_valid pulsing every 4 cycles.
- **Pause/resume:** play = 0 mid-note at idx 1 → fcw_out = 0 the next cycle. play = 1 → fcw_out = 24'h010905 with a valid pulse, then a full 4-cycle note.
- **tempo = 0 and restart:** tempo = 0 → a new note every cycle. restart pulse → fcw_out = 0 and seq_idx = 0 the next cycle, then playback resumes from entry 0.
- **Mid-play reconfiguration:** rst_n asserted mid-note → outputs clear asynchronously. Lower seq_last from 3 to 1 while idx = 3 → the next note is entry 0.

Source files
------------

// File: rtl/fcw_seq_table_pkg.sv
// Shared types and default tone constants for the FCW table / sequencer.
package fcw_pkg;

    localparam int DEFAULT_WIDTH = 24;

    localparam logic [23:0] FCW_A4 = 24'h00EC3C;
    localparam logic [23:0] FCW_B4 = 24'h010905;
    localparam logic [23:0] FCW_C5 = 24'h01194B;
    localparam logic [23:0] FCW_D5 = 24'h013BCD;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        PAUSE
    } seq_state_e;

    function automatic logic [23:0] fcw_default(int idx);
        case (idx)
            0: return FCW_A4;
            1: return FCW_B4;
            2: return FCW_C5;
            3: return FCW_D5;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/fcw_seq_table_if.sv
// Host read/write port of the FCW table.
interface fcw_seq_table_if #(
    parameter int WIDTH  = fcw_pkg::DEFAULT_WIDTH,
    parameter int ADDR_W = 3
);
    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  d_in;
    logic [WIDTH-1:0]  d_out;

    modport master (
        output wr_en, rd_en, addr, d_in,
        input  d_out
    );

    modport slave (
        input  wr_en, rd_en, addr, d_in,
        output d_out
    );
endinterface

// File: rtl/fcw_seq_table_ctrl.sv
// Note sequencer: FSM, note-duration counter and table index generator.
module fcw_seq_ctrl
    import fcw_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int ADDR_W  = 3,
    parameter int TEMPO_W = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               play,
    input  logic               restart,
    input  logic [ADDR_W-1:0]  seq_last,
    input  logic [TEMPO_W-1:0] tempo,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic [WIDTH-1:0]   rd_data,
    output logic [WIDTH-1:0]   fcw_out,
    output logic               fcw_valid,
    output logic [ADDR_W-1:0]  seq_idx
);

    seq_state_e         state_q, state_d;
    logic [ADDR_W-1:0]  idx_q, idx_d, nidx;
    logic [TEMPO_W-1:0] cnt_q, cnt_d, tlast;
    logic [WIDTH-1:0]   fcw_q, fcw_d;
    logic               vld_q, vld_d;

    always_comb begin
        tlast = (tempo == '0) ? '0 : tempo - TEMPO_W'(1);
        // Out-of-range index (seq_last lowered mid-play) also wraps to 0.
        nidx  = (idx_q >= seq_last) ? '0 : idx_q + ADDR_W'(1);

        case (state_q)
            IDLE:    rd_addr = '0;
            PLAY:    rd_addr = nidx;
            default: rd_addr = idx_q;
        endcase

        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        fcw_d   = fcw_q;
        vld_d   = 1'b0;

        if (restart) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
            fcw_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    idx_d = '0;
                    cnt_d = '0;
                    fcw_d = '0;
                    if (play) begin
                        fcw_d   = rd_data;
                        vld_d   = 1'b1;
                        state_d = PLAY;
                    end
                end
                PLAY: begin
                    if (!play) begin
                        state_d = PAUSE;
                        fcw_d   = '0;
                        cnt_d   = '0;
                    end else if (cnt_q == tlast) begin
                        idx_d = nidx;
                        fcw_d = rd_data;
                        vld_d = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + TEMPO_W'(1);
                    end
                end
                PAUSE: begin
                    fcw_d = '0;
                    cnt_d = '0;
                    if (play) begin
                        fcw_d   = rd_data;
                        vld_d   = 1'b1;
                        state_d = PLAY;
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                    fcw_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            fcw_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            fcw_q   <= fcw_d;
            vld_q   <= vld_d;
        end
    end

    assign fcw_out   = fcw_q;
    assign fcw_valid = vld_q;
    assign seq_idx   = idx_q;

endmodule

// File: rtl/fcw_seq_table.sv
// FCW table with host port and note sequencer.
// Define FCW_SEQ_DEFAULTS_EN to reset the table to the default tone set.
module fcw_seq_table
    import fcw_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int DEPTH   = 8,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int TEMPO_W = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    fcw_seq_table_if.slave     host,
    input  logic               play,
    input  logic               restart,
    input  logic [ADDR_W-1:0]  seq_last,
    input  logic [TEMPO_W-1:0] tempo,
    output logic [WIDTH-1:0]   fcw_out,
    output logic               fcw_valid,
    output logic [ADDR_W-1:0]  seq_idx
);

    logic [WIDTH-1:0]  tbl_q [DEPTH];
    logic [WIDTH-1:0]  tbl_d [DEPTH];
    logic [WIDTH-1:0]  d_out_q, d_out_d;
    logic [ADDR_W-1:0] seq_rd_addr;

    // Reads see tbl_q, so a same-cycle write to the same entry returns old data.
    always_comb begin
        tbl_d = tbl_q;
        if (host.wr_en) tbl_d[host.addr] = host.d_in;
        d_out_d = host.rd_en ? tbl_q[host.addr] : d_out_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
`ifdef FCW_SEQ_DEFAULTS_EN
                tbl_q[i] <= WIDTH'(fcw_default(i));
`else
                tbl_q[i] <= '0;
`endif
            end
            d_out_q <= '0;
        end else begin
            tbl_q   <= tbl_d;
            d_out_q <= d_out_d;
        end
    end

    assign host.d_out = d_out_q;

    fcw_seq_ctrl #(
        .WIDTH   (WIDTH),
        .ADDR_W  (ADDR_W),
        .TEMPO_W (TEMPO_W)
    ) u_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .play      (play),
        .restart   (restart),
        .seq_last  (seq_last),
        .tempo     (tempo),
        .rd_addr   (seq_rd_addr),
        .rd_data   (tbl_q[seq_rd_addr]),
        .fcw_out   (fcw_out),
        .fcw_valid (fcw_valid),
        .seq_idx   (seq_idx)
    );

endmodule
